mips_regfile: RTL and testbench
===============================

Name: mips_regfile

Overview:
General-purpose register file for the multicycle MIPS datapath. It sits directly upstream of the A/B operand register pair. Each cycle it presents the rs/rt operands on two combinational read ports, and it accepts one synchronous write per cycle from the write-back mux (ALUOut or MDR). It also provides a third read port for bench/debug visibility.

Parameters:
- WIDTH, 32, data width of each register in bits.
- DEPTH_LOG2, 5, address width; the file holds 2**DEPTH_LOG2 registers.
- BYPASS, 1, selects same-cycle write-to-read forwarding: 1 = forward, 0 = no forwarding.

Ports:
- clk  input  1  single clock; all writes happen on its rising edge.
- reset  input  1  asynchronous reset, active-high.
- RdAddr1  input  DEPTH_LOG2  read port 1 address (rs, instr[25:21]).
- RdAddr2  input  DEPTH_LOG2  read port 2 address (rt, instr[20:16]).
- DbgAddr  input  DEPTH_LOG2  debug read address.
- WrEn  input  1  write enable (RegWrite from control).
- WrAddr  input  DEPTH_LOG2  write address (rt or rd, selected by RegDst upstream).
- WrData  input  WIDTH  write data.
- RdData1  output  WIDTH  read data for RdAddr1; feeds DataIn1 of the A/B register stage.
- RdData2  output  WIDTH  read data for RdAddr2; feeds DataIn2 of the A/B register stage.
- DbgData  output  WIDTH  read data for DbgAddr.
- WrCount  output  16  saturating count of committed writes.

Behaviour:
- Reset:
  - Asserting reset (async, high) clears every register to 0 and WrCount to 0 immediately, with no clock edge needed.
  - While reset is high, writes are ignored and all read outputs show 0.
  - Deassertion is synchronous to clk from the integration side; the first write can commit on the first rising edge after reset falls.
- Register 0:
  - Always reads 0.
  - A write to address 0 is discarded, and WrCount does not increment for it.
  - The BYPASS path never forwards to address 0.
- Write:
  - On the rising edge of clk with WrEn=1 and WrAddr!=0, reg[WrAddr] <= WrData.
  - WrEn=0 leaves all storage unchanged.
- Read:
  - RdData1, RdData2 and DbgData are combinational on the address and storage, with zero-cycle latency.
  - A value written at edge N is visible on the read ports from edge N onward (after the update).
- BYPASS=1:
  - If WrEn=1, WrAddr!=0 and RdAddrX==WrAddr in the same cycle, RdDataX = WrData before the edge.
  - This applies to both read ports independently, and to DbgData.
  - Both ports may bypass simultaneously when their addresses are equal.
- BYPASS=0: reads return stored contents only.
- WrCount:
  - Increments by 1 on each committed write (WrEn=1, WrAddr!=0).
  - Saturates at 16'hFFFF with no wrap.
- Simultaneous events:
  - Reset asserted in the same cycle as a write: reset wins and the register stays 0.
  - Reading an address while a different address is written: the read shows the old stored value of the read address.
- Widths: no arithmetic on the data; WrData is stored bit-exact. Address values are always in range because DEPTH is a full power of two.

Test Plan:
- Reset then read:
  - Stimulus: pulse reset mid-simulation after loading reg5=32'hDEADBEEF.
  - Response: RdData1 at RdAddr1=5 drops to 0 before the next clk edge, and WrCount=0.
- R0 protection:
  - Stimulus: WrEn=1, WrAddr=0, WrData=32'hFFFFFFFF, one edge; then read address 0 on both ports.
  - Response: both read ports show 0 and WrCount is unchanged.
- Write/read all registers:
  - Stimulus: write reg[i]=i*32'h01010101 for i=1..31, then sweep RdAddr1/RdAddr2 with opposite orderings.
  - Response: each port returns the matching value, and WrCount=31.
- Bypass:
  - Stimulus: BYPASS=1, WrEn=1, WrAddr=9, WrData=32'h12345678, RdAddr1=RdAddr2=9 before the edge.
  - Response: both ports show 32'h12345678 pre-edge.
  - With BYPASS=0, the same stimulus shows the old value pre-edge and the new value post-edge.
- Reset collision:
  - Stimulus: reset held high across an edge with WrEn=1, WrAddr=3, WrData=32'hA5A5A5A5.
  - Response: reg3 reads 0 after reset falls.
- WrCount saturation:
  - Stimulus: issue 65540 committed writes.
  - Response: WrCount=16'hFFFF and stays there, and data writes continue to commit.

Source files
------------

// File: rtl/mips_regfile.sv
// mips_regfile: general-purpose register file for the multicycle MIPS datapath.
// Two combinational operand read ports, one debug read port, one synchronous
// write port, optional same-cycle write-to-read forwarding and a saturating
// count of committed writes.
module mips_regfile #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 5,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DEPTH_LOG2-1:0] RdAddr1,
    input  logic [DEPTH_LOG2-1:0] RdAddr2,
    input  logic [DEPTH_LOG2-1:0] DbgAddr,
    input  logic                  WrEn,
    input  logic [DEPTH_LOG2-1:0] WrAddr,
    input  logic [WIDTH-1:0]      WrData,
    output logic [WIDTH-1:0]      RdData1,
    output logic [WIDTH-1:0]      RdData2,
    output logic [WIDTH-1:0]      DbgData,
    output logic [15:0]           WrCount
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [15:0]      r_wr_count;
    logic             w_commit;

    // A write commits only when enabled and not aimed at the hardwired zero register.
    assign w_commit = WrEn && (WrAddr != '0);

    // Read-port selection: reset forces zero, r0 is always zero, and the optional
    // forwarding path returns the in-flight write data for a matching address.
    function automatic logic [WIDTH-1:0] f_port(
        input logic [DEPTH_LOG2-1:0] addr,
        input logic [WIDTH-1:0]      stored,
        input logic                  rst,
        input logic                  commit,
        input logic [DEPTH_LOG2-1:0] waddr,
        input logic [WIDTH-1:0]      wdata
    );
        if (rst || (addr == '0)) begin
            return '0;
        end
        if ((BYPASS != 0) && commit && (addr == waddr)) begin
            return wdata;
        end
        return stored;
    endfunction

    // Storage update: async clear of the whole file, one write per rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem <= '{default: '0};
        end else if (w_commit) begin
            r_mem[WrAddr] <= WrData;
        end
    end

    // Committed-write counter, saturating at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_count <= '0;
        end else if (w_commit && (r_wr_count != '1)) begin
            r_wr_count <= r_wr_count + 16'd1;
        end
    end

    // Zero-latency read ports.
    always_comb begin
        RdData1 = f_port(RdAddr1, r_mem[RdAddr1], reset, w_commit, WrAddr, WrData);
        RdData2 = f_port(RdAddr2, r_mem[RdAddr2], reset, w_commit, WrAddr, WrData);
        DbgData = f_port(DbgAddr, r_mem[DbgAddr], reset, w_commit, WrAddr, WrData);
    end

    assign WrCount = r_wr_count;

endmodule

// File: tb/tb_mips_regfile.sv
// tb_mips_regfile: directed self-checking bench for mips_regfile, with one
// forwarding instance and one non-forwarding instance sharing the same stimulus.
module tb_mips_regfile;

    logic        clk;
    logic        reset;
    logic [4:0]  RdAddr1;
    logic [4:0]  RdAddr2;
    logic [4:0]  DbgAddr;
    logic        WrEn;
    logic [4:0]  WrAddr;
    logic [31:0] WrData;
    logic [31:0] RdData1, RdData2, DbgData;
    logic [15:0] WrCount;
    logic [31:0] nb_RdData1, nb_RdData2, nb_DbgData;
    logic [15:0] nb_WrCount;

    int errors = 0;
    int checks = 0;

    mips_regfile #(.WIDTH(32), .DEPTH_LOG2(5), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .RdAddr1(RdAddr1), .RdAddr2(RdAddr2),
        .DbgAddr(DbgAddr), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .RdData1(RdData1), .RdData2(RdData2), .DbgData(DbgData), .WrCount(WrCount)
    );

    mips_regfile #(.WIDTH(32), .DEPTH_LOG2(5), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .RdAddr1(RdAddr1), .RdAddr2(RdAddr2),
        .DbgAddr(DbgAddr), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .RdData1(nb_RdData1), .RdData2(nb_RdData2), .DbgData(nb_DbgData), .WrCount(nb_WrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are then changed away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Under reset even a forwarding-eligible write must read back as zero.
        WrEn = 1'b1; WrAddr = 5'd7; WrData = 32'h11112222;
        RdAddr1 = 5'd7; RdAddr2 = 5'd7; DbgAddr = 5'd7;
        #1;
        checks++; if (RdData1 !== 32'h0) begin errors++; $display("FAIL reset_rd1: got %h want %h", RdData1, 32'h0); end
        checks++; if (RdData2 !== 32'h0) begin errors++; $display("FAIL reset_rd2: got %h want %h", RdData2, 32'h0); end
        checks++; if (DbgData !== 32'h0) begin errors++; $display("FAIL reset_dbg: got %h want %h", DbgData, 32'h0); end
        checks++; if (WrCount !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h want %h", WrCount, 16'h0); end
        tick();
        WrEn = 1'b0;
        reset = 1'b0;
        #1;
        checks++; if (RdData1 !== 32'h0) begin errors++; $display("FAIL reset_no_write: got %h want %h", RdData1, 32'h0); end
    endtask

    task automatic test_r0();
        WrEn = 1'b1; WrAddr = 5'd0; WrData = 32'hFFFFFFFF;
        RdAddr1 = 5'd0; RdAddr2 = 5'd0; DbgAddr = 5'd0;
        #1;
        checks++; if (RdData1 !== 32'h0) begin errors++; $display("FAIL r0_nobypass: got %h want %h", RdData1, 32'h0); end
        tick();
        WrEn = 1'b0;
        #1;
        checks++; if (RdData1 !== 32'h0) begin errors++; $display("FAIL r0_rd1: got %h want %h", RdData1, 32'h0); end
        checks++; if (RdData2 !== 32'h0) begin errors++; $display("FAIL r0_rd2: got %h want %h", RdData2, 32'h0); end
        checks++; if (WrCount !== 16'h0) begin errors++; $display("FAIL r0_cnt: got %h want %h", WrCount, 16'h0); end
    endtask

    task automatic test_write_all();
        for (int i = 1; i < 32; i++) begin
            WrEn = 1'b1; WrAddr = 5'(i); WrData = i * 32'h01010101;
            tick();
        end
        WrEn = 1'b0;
        for (int i = 0; i < 32; i++) begin
            logic [31:0] e1, e2;
            RdAddr1 = 5'(i); RdAddr2 = 5'(31 - i); DbgAddr = 5'(i);
            e1 = i * 32'h01010101;
            e2 = (31 - i) * 32'h01010101;
            #1;
            checks++; if (RdData1 !== e1) begin errors++; $display("FAIL sweep_rd1[%0d]: got %h want %h", i, RdData1, e1); end
            checks++; if (RdData2 !== e2) begin errors++; $display("FAIL sweep_rd2[%0d]: got %h want %h", 31 - i, RdData2, e2); end
            checks++; if (DbgData !== e1) begin errors++; $display("FAIL sweep_dbg[%0d]: got %h want %h", i, DbgData, e1); end
            checks++; if (nb_RdData1 !== e1) begin errors++; $display("FAIL sweep_nb_rd1[%0d]: got %h want %h", i, nb_RdData1, e1); end
        end
        checks++; if (WrCount !== 16'd31) begin errors++; $display("FAIL all_cnt: got %0d want %0d", WrCount, 31); end
        checks++; if (nb_WrCount !== 16'd31) begin errors++; $display("FAIL all_nb_cnt: got %0d want %0d", nb_WrCount, 31); end
    endtask

    task automatic test_other_addr();
        // Writing reg4 while reading reg5 shows reg5's stored value.
        WrEn = 1'b1; WrAddr = 5'd4; WrData = 32'hCAFEF00D;
        RdAddr1 = 5'd5; RdAddr2 = 5'd4; DbgAddr = 5'd5;
        #1;
        checks++; if (RdData1 !== 32'h05050505) begin errors++; $display("FAIL other_rd1: got %h want %h", RdData1, 32'h05050505); end
        checks++; if (RdData2 !== 32'hCAFEF00D) begin errors++; $display("FAIL other_rd2_fwd: got %h want %h", RdData2, 32'hCAFEF00D); end
        checks++; if (nb_RdData2 !== 32'h04040404) begin errors++; $display("FAIL other_nb_rd2: got %h want %h", nb_RdData2, 32'h04040404); end
        tick();
        WrEn = 1'b0;
        #1;
        checks++; if (nb_RdData2 !== 32'hCAFEF00D) begin errors++; $display("FAIL other_nb_post: got %h want %h", nb_RdData2, 32'hCAFEF00D); end
    endtask

    task automatic test_bypass();
        WrEn = 1'b1; WrAddr = 5'd9; WrData = 32'h12345678;
        RdAddr1 = 5'd9; RdAddr2 = 5'd9; DbgAddr = 5'd9;
        #1;
        checks++; if (RdData1 !== 32'h12345678) begin errors++; $display("FAIL byp_rd1: got %h want %h", RdData1, 32'h12345678); end
        checks++; if (RdData2 !== 32'h12345678) begin errors++; $display("FAIL byp_rd2: got %h want %h", RdData2, 32'h12345678); end
        checks++; if (DbgData !== 32'h12345678) begin errors++; $display("FAIL byp_dbg: got %h want %h", DbgData, 32'h12345678); end
        checks++; if (nb_RdData1 !== 32'h09090909) begin errors++; $display("FAIL nobyp_pre_rd1: got %h want %h", nb_RdData1, 32'h09090909); end
        checks++; if (nb_RdData2 !== 32'h09090909) begin errors++; $display("FAIL nobyp_pre_rd2: got %h want %h", nb_RdData2, 32'h09090909); end
        tick();
        WrEn = 1'b0;
        #1;
        checks++; if (RdData1 !== 32'h12345678) begin errors++; $display("FAIL byp_post_rd1: got %h want %h", RdData1, 32'h12345678); end
        checks++; if (nb_RdData1 !== 32'h12345678) begin errors++; $display("FAIL nobyp_post_rd1: got %h want %h", nb_RdData1, 32'h12345678); end
        checks++; if (WrCount !== 16'd33) begin errors++; $display("FAIL byp_cnt: got %0d want %0d", WrCount, 33); end
    endtask

    task automatic test_reset_async();
        WrEn = 1'b1; WrAddr = 5'd5; WrData = 32'hDEADBEEF;
        tick();
        WrEn = 1'b0; RdAddr1 = 5'd5;
        #1;
        checks++; if (RdData1 !== 32'hDEADBEEF) begin errors++; $display("FAIL load5: got %h want %h", RdData1, 32'hDEADBEEF); end
        // Mid-cycle reset pulse: outputs must clear with no clock edge.
        #1 reset = 1'b1;
        #1;
        checks++; if (RdData1 !== 32'h0) begin errors++; $display("FAIL async_rd1: got %h want %h", RdData1, 32'h0); end
        checks++; if (WrCount !== 16'h0) begin errors++; $display("FAIL async_cnt: got %h want %h", WrCount, 16'h0); end
        // Hold reset across an edge with a write pending.
        WrEn = 1'b1; WrAddr = 5'd3; WrData = 32'hA5A5A5A5;
        tick();
        reset = 1'b0; WrEn = 1'b0;
        RdAddr1 = 5'd3; RdAddr2 = 5'd5; DbgAddr = 5'd9;
        #1;
        checks++; if (RdData1 !== 32'h0) begin errors++; $display("FAIL collide_rd3: got %h want %h", RdData1, 32'h0); end
        checks++; if (RdData2 !== 32'h0) begin errors++; $display("FAIL collide_rd5: got %h want %h", RdData2, 32'h0); end
        checks++; if (DbgData !== 32'h0) begin errors++; $display("FAIL collide_dbg9: got %h want %h", DbgData, 32'h0); end
        checks++; if (WrCount !== 16'h0) begin errors++; $display("FAIL collide_cnt: got %h want %h", WrCount, 16'h0); end
    endtask

    task automatic test_saturation();
        logic [4:0]  last_addr;
        logic [31:0] last_data;
        last_addr = '0;
        last_data = '0;
        for (int k = 0; k < 65540; k++) begin
            WrEn = 1'b1; WrAddr = 5'((k % 31) + 1); WrData = 32'(k);
            last_addr = WrAddr; last_data = WrData;
            tick();
        end
        WrEn = 1'b0; RdAddr1 = last_addr;
        #1;
        checks++; if (WrCount !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt: got %h want %h", WrCount, 16'hFFFF); end
        checks++; if (nb_WrCount !== 16'hFFFF) begin errors++; $display("FAIL sat_nb_cnt: got %h want %h", nb_WrCount, 16'hFFFF); end
        checks++; if (RdData1 !== last_data) begin errors++; $display("FAIL sat_last_data: got %h want %h", RdData1, last_data); end
        WrEn = 1'b1; WrAddr = 5'd12; WrData = 32'h0BADCAFE;
        tick();
        WrEn = 1'b0; RdAddr1 = 5'd12;
        #1;
        checks++; if (WrCount !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want %h", WrCount, 16'hFFFF); end
        checks++; if (RdData1 !== 32'h0BADCAFE) begin errors++; $display("FAIL sat_commit: got %h want %h", RdData1, 32'h0BADCAFE); end
    endtask

    initial begin
        reset = 1'b1; WrEn = 1'b0; WrAddr = '0; WrData = '0;
        RdAddr1 = '0; RdAddr2 = '0; DbgAddr = '0;
        tick();
        test_reset();
        test_r0();
        test_write_all();
        test_other_addr();
        test_bypass();
        test_reset_async();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
